// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encoding, lamp codes and timer width helper for the phase controller
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN   = 2'd0,
    YELLOW  = 2'd1,
    ALL_RED = 2'd2
  } state_e;

  // Per-phase lamp field encoding {red, yellow, green}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // Width of a counter that must reach the largest of the three durations
  function automatic int cnt_width(input int green_max, input int yellow_t, input int all_red_t);
    int m;
    m = green_max;
    if (yellow_t > m) m = yellow_t;
    if (all_red_t > m) m = all_red_t;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/traffic_phase_controller_rr_phase_select.sv
// rtl/traffic_phase_controller_rr_phase_select.sv - round-robin search for the next requesting phase after cur
module rr_phase_select #(
  parameter int NUM_PHASES = 4,
  parameter int IW         = $clog2(NUM_PHASES)
) (
  input  logic [NUM_PHASES-1:0] pending_i,
  input  logic [IW-1:0]         cur_i,
  output logic [IW-1:0]         next_o,
  output logic                  valid_o
);

  logic [IW-1:0] idx;

  // Walk cur+N-1 down to cur+1 so the nearest requester after cur is the last one written
  always_comb begin
    next_o  = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int k = NUM_PHASES - 1; k >= 1; k--) begin
      idx = IW'((int'(cur_i) + k) % NUM_PHASES);
      if (pending_i[idx]) begin
        next_o  = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// rtl/traffic_phase_controller.sv - round-robin multi-phase signal controller; TRAFFIC_PREEMPT_EN adds preemption inputs
module traffic_phase_controller #(
  parameter int NUM_PHASES = 4,
  parameter int GREEN_MIN  = 8,
  parameter int GREEN_MAX  = 20,
  parameter int YELLOW_T   = 3,
  parameter int ALL_RED_T  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PHASES-1:0]           vehicle_present,
`ifdef TRAFFIC_PREEMPT_EN
  input  logic                            preempt,
  input  logic [$clog2(NUM_PHASES)-1:0]   preempt_phase,
`endif
  output logic [3*NUM_PHASES-1:0]         lights,
  output logic [$clog2(NUM_PHASES)-1:0]   active_phase,
  output logic                            phase_change,
  output logic [NUM_PHASES-1:0]           pending
);

  import traffic_pkg::*;

  localparam int IW = $clog2(NUM_PHASES);
  localparam int CW = cnt_width(GREEN_MAX, YELLOW_T, ALL_RED_T);

  localparam logic [CW-1:0] GMIN_M1 = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX_M1 = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YEL_M1  = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] AR_M1   = CW'(ALL_RED_T - 1);

  state_e                state_q;
  logic [IW-1:0]         cur_q;
  logic [IW-1:0]         next_q;
  logic [CW-1:0]         cnt_q;
  logic [NUM_PHASES-1:0] pending_q;
  logic [NUM_PHASES-1:0] pending_d;
  logic                  phase_change_q;

  logic [IW-1:0]         rr_next;
  logic                  rr_valid;
  logic [IW-1:0]         next_sel;
  logic [IW-1:0]         next_eff;
  logic                  vp_cur;
  logic                  go_yellow;
  logic                  enter_green;

  // rr_valid is exactly "some phase other than cur is pending" since the search skips cur
  rr_phase_select #(
    .NUM_PHASES(NUM_PHASES),
    .IW        (IW)
  ) u_rr (
    .pending_i(pending_q),
    .cur_i    (cur_q),
    .next_o   (rr_next),
    .valid_o  (rr_valid)
  );

  // Detector level of the phase currently being served
  always_comb begin
    vp_cur = 1'b0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (IW'(i) == cur_q) vp_cur = vehicle_present[i];
    end
  end

  // Green exit decision and the phase to hand over to
  always_comb begin
    go_yellow   = rr_valid && ((cnt_q >= GMAX_M1) || ((cnt_q >= GMIN_M1) && !vp_cur));
    next_sel    = rr_next;
    next_eff    = next_q;
    enter_green = (state_q == ALL_RED) && (cnt_q == AR_M1);
`ifdef TRAFFIC_PREEMPT_EN
    if (preempt) begin
      go_yellow = (preempt_phase != cur_q);
      next_sel  = preempt_phase;
      next_eff  = preempt_phase;
    end
`endif
  end

  // Sticky requests: set on detection unless already being served; clearing on green entry wins
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (vehicle_present[i] && ((IW'(i) != cur_q) || (state_q != GREEN))) pending_d[i] = 1'b1;
      if (enter_green && (IW'(i) == next_eff)) pending_d[i] = 1'b0;
    end
  end

  // Phase sequencing FSM with its dwell counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= GREEN;
      cur_q          <= '0;
      next_q         <= '0;
      cnt_q          <= '0;
      pending_q      <= '0;
      phase_change_q <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      phase_change_q <= 1'b0;
      case (state_q)
        GREEN: begin
          if (go_yellow) begin
            state_q <= YELLOW;
            cnt_q   <= '0;
            next_q  <= next_sel;
          end else if (cnt_q < GMAX_M1) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        YELLOW: begin
          next_q <= next_eff;
          if (cnt_q == YEL_M1) begin
            state_q <= ALL_RED;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ALL_RED: begin
          next_q <= next_eff;
          if (cnt_q == AR_M1) begin
            state_q        <= GREEN;
            cur_q          <= next_eff;
            cnt_q          <= '0;
            phase_change_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= GREEN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Lamp decode from state and current phase only
  always_comb begin
    lights = {NUM_PHASES{LAMP_RED}};
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (IW'(i) == cur_q) begin
        if (state_q == GREEN)       lights[3*i +: 3] = LAMP_GRN;
        else if (state_q == YELLOW) lights[3*i +: 3] = LAMP_YEL;
      end
    end
  end

  assign active_phase = cur_q;
  assign phase_change = phase_change_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb/tb_traffic_phase_controller.sv - directed vector bench for traffic_phase_controller (4 phases, default timing)
module tb_traffic_phase_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  vp;
  logic [11:0] lights;
  logic [1:0]  active_phase;
  logic        phase_change;
  logic [3:0]  pending;
`ifdef TRAFFIC_PREEMPT_EN
  logic        preempt;
  logic [1:0]  preempt_phase;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  traffic_phase_controller #(
    .NUM_PHASES(4),
    .GREEN_MIN (8),
    .GREEN_MAX (20),
    .YELLOW_T  (3),
    .ALL_RED_T (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .vehicle_present(vp),
`ifdef TRAFFIC_PREEMPT_EN
    .preempt        (preempt),
    .preempt_phase  (preempt_phase),
`endif
    .lights         (lights),
    .active_phase   (active_phase),
    .phase_change   (phase_change),
    .pending        (pending)
  );

  typedef struct {
    logic [3:0]  vp;
    int          n;
    logic [11:0] lights;
    logic [1:0]  phase;
    logic        pc;
    logic [3:0]  pend;
  } vec_t;

  vec_t vecs[23];

  localparam logic [11:0] L_P0G = 12'b100_100_100_001;
  localparam logic [11:0] L_P0Y = 12'b100_100_100_010;
  localparam logic [11:0] L_P2G = 12'b100_001_100_100;
  localparam logic [11:0] L_P2Y = 12'b100_010_100_100;
  localparam logic [11:0] L_P3G = 12'b001_100_100_100;
  localparam logic [11:0] L_P3Y = 12'b010_100_100_100;
  localparam logic [11:0] L_ARD = 12'b100_100_100_100;

  function automatic vec_t mk(input logic [3:0] v, input int n, input logic [11:0] l,
                              input logic [1:0] ph, input logic pc, input logic [3:0] pd);
    vec_t r;
    r.vp = v; r.n = n; r.lights = l; r.phase = ph; r.pc = pc; r.pend = pd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    int nonred;
    logic ok;
    @(posedge clk);
    #1;
    nonred = 0;
    ok = 1'b1;
    for (int p = 0; p < 4; p++) begin
      if (!$onehot(lights[3*p +: 3])) ok = 1'b0;
      if (lights[3*p +: 3] != 3'b100) nonred++;
    end
    if (nonred > 1) ok = 1'b0;
    chk("safety", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    vecs[0]  = mk(4'b0000,  0, L_P0G, 2'd0, 1'b0, 4'b0000);
    vecs[1]  = mk(4'b0000,  5, L_P0G, 2'd0, 1'b0, 4'b0000);
    vecs[2]  = mk(4'b0100,  1, L_P0G, 2'd0, 1'b0, 4'b0100);
    vecs[3]  = mk(4'b0000,  1, L_P0G, 2'd0, 1'b0, 4'b0100);
    vecs[4]  = mk(4'b0000,  1, L_P0Y, 2'd0, 1'b0, 4'b0100);
    vecs[5]  = mk(4'b0000,  2, L_P0Y, 2'd0, 1'b0, 4'b0100);
    vecs[6]  = mk(4'b0000,  1, L_ARD, 2'd0, 1'b0, 4'b0100);
    vecs[7]  = mk(4'b0000,  1, L_ARD, 2'd0, 1'b0, 4'b0100);
    vecs[8]  = mk(4'b0000,  1, L_P2G, 2'd2, 1'b1, 4'b0000);
    vecs[9]  = mk(4'b0000,  1, L_P2G, 2'd2, 1'b0, 4'b0000);
    vecs[10] = mk(4'b1100,  1, L_P2G, 2'd2, 1'b0, 4'b1000);
    vecs[11] = mk(4'b0100, 17, L_P2G, 2'd2, 1'b0, 4'b1000);
    vecs[12] = mk(4'b0100,  1, L_P2Y, 2'd2, 1'b0, 4'b1000);
    vecs[13] = mk(4'b0000,  5, L_P3G, 2'd3, 1'b1, 4'b0000);
    vecs[14] = mk(4'b0101,  1, L_P3G, 2'd3, 1'b0, 4'b0101);
    vecs[15] = mk(4'b0000,  6, L_P3G, 2'd3, 1'b0, 4'b0101);
    vecs[16] = mk(4'b0000,  1, L_P3Y, 2'd3, 1'b0, 4'b0101);
    vecs[17] = mk(4'b0000,  5, L_P0G, 2'd0, 1'b1, 4'b0100);
    vecs[18] = mk(4'b0000,  8, L_P0Y, 2'd0, 1'b0, 4'b0100);
    vecs[19] = mk(4'b0000,  5, L_P2G, 2'd2, 1'b1, 4'b0000);
    vecs[20] = mk(4'b0000, 60, L_P2G, 2'd2, 1'b0, 4'b0000);
    vecs[21] = mk(4'b0010,  1, L_P2G, 2'd2, 1'b0, 4'b0010);
    vecs[22] = mk(4'b0000,  1, L_P2Y, 2'd2, 1'b0, 4'b0010);

    rst = 1'b0;
    vp  = 4'b0000;
`ifdef TRAFFIC_PREEMPT_EN
    preempt       = 1'b0;
    preempt_phase = 2'd0;
`endif
    repeat (2) tick();
    rst = 1'b1;

    // Idle rest: phase 0 holds green and never announces a change
    for (int c = 0; c < 100; c++) begin
      tick();
      chk("idle_pc", {31'd0, phase_change}, 32'd0);
    end
    chk("idle_lights", {20'd0, lights}, {20'd0, L_P0G});
    chk("idle_phase", {30'd0, active_phase}, 32'd0);

    rst = 1'b0;
    tick();
    rst = 1'b1;

    for (int i = 0; i < 23; i++) begin
      vp = vecs[i].vp;
      repeat (vecs[i].n) tick();
      chk($sformatf("v%0d_lights", i), {20'd0, lights}, {20'd0, vecs[i].lights});
      chk($sformatf("v%0d_phase", i), {30'd0, active_phase}, {30'd0, vecs[i].phase});
      chk($sformatf("v%0d_pc", i), {31'd0, phase_change}, {31'd0, vecs[i].pc});
      chk($sformatf("v%0d_pend", i), {28'd0, pending}, {28'd0, vecs[i].pend});
    end

    // Requests during clearance latch, then an async reset in ALL_RED wipes everything
    vp = 4'b0001;
    repeat (3) tick();
    chk("ar_lights", {20'd0, lights}, {20'd0, L_ARD});
    chk("ar_pend", {28'd0, pending}, 32'h3);
    rst = 1'b0;
    #1;
    chk("rst_lights", {20'd0, lights}, {20'd0, L_P0G});
    chk("rst_pend", {28'd0, pending}, 32'd0);
    chk("rst_phase", {30'd0, active_phase}, 32'd0);
    chk("rst_pc", {31'd0, phase_change}, 32'd0);
    vp = 4'b0000;
    tick();
    rst = 1'b1;

`ifdef TRAFFIC_PREEMPT_EN
    tick();
    preempt       = 1'b1;
    preempt_phase = 2'd3;
    tick();
    chk("pre_yel", {20'd0, lights}, {20'd0, L_P0Y});
    repeat (5) tick();
    chk("pre_grn", {20'd0, lights}, {20'd0, L_P3G});
    chk("pre_pc", {31'd0, phase_change}, 32'd1);
    vp = 4'b0010;
    repeat (30) tick();
    chk("pre_hold", {20'd0, lights}, {20'd0, L_P3G});
    preempt = 1'b0;
    vp      = 4'b0000;
    tick();
    chk("pre_release", {20'd0, lights}, {20'd0, L_P3Y});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
